// File: rtl/issue_div_fifo.sv
// -----------------------------------------------------------------------------
// issue_div_fifo
// Show-ahead FIFO between the issue stage and the divide execution unit.
// Issue enqueues issue_execute_pack_t entries; the divide unit sees the head
// entry combinationally from registered storage, with a valid flag, and pops
// it in the same cycle it consumes it. A commit-stage flush empties the queue
// in one cycle.
//
// Ports
//   clk                            : clock, rising-edge
//   rst                            : asynchronous reset, active low
//   issue_div_fifo_data_in         : entry to enqueue
//   issue_div_fifo_push            : enqueue request
//   issue_div_fifo_full            : no free entry
//   issue_div_fifo_data_out        : head entry, all-zero when empty
//   issue_div_fifo_data_out_valid  : head entry present
//   issue_div_fifo_pop             : dequeue head
//   issue_div_fifo_count           : occupied entries, 0..DEPTH
//   commit_feedback_pack           : flush when enable && flush
// -----------------------------------------------------------------------------
package issue_div_fifo_pkg;

  typedef struct packed {
    logic        enable;
    logic [5:0]  rob_id;
    logic [1:0]  div_op;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
  } issue_execute_pack_t;

  typedef struct packed {
    logic enable;
    logic flush;
  } commit_feedback_pack_t;

endpackage

module issue_div_fifo
  import issue_div_fifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  issue_execute_pack_t         issue_div_fifo_data_in,
  input  logic                        issue_div_fifo_push,
  output logic                        issue_div_fifo_full,
  output issue_execute_pack_t         issue_div_fifo_data_out,
  output logic                        issue_div_fifo_data_out_valid,
  input  logic                        issue_div_fifo_pop,
  output logic [$clog2(DEPTH):0]      issue_div_fifo_count,
  input  commit_feedback_pack_t       commit_feedback_pack
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  issue_execute_pack_t  r_mem [DEPTH];

  logic          w_empty;
  logic          w_full;
  logic          w_flush;
  logic          w_push_eff;
  logic          w_pop_eff;
  logic [AW-1:0] w_widx;
  logic [AW-1:0] w_ridx;

  assign w_widx  = r_wptr[AW-1:0];
  assign w_ridx  = r_rptr[AW-1:0];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (w_widx == w_ridx) && (r_wptr[AW] != r_rptr[AW]);
  assign w_flush = commit_feedback_pack.enable && commit_feedback_pack.flush;

  // Flush dominates both push and pop; a push into a full queue is dropped.
  assign w_push_eff = issue_div_fifo_push && !w_full  && !w_flush;
  assign w_pop_eff  = issue_div_fifo_pop  && !w_empty && !w_flush;

  // Pointer state: async reset, flush clears, otherwise advance on accepted events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= {PW{1'b0}};
      r_rptr <= {PW{1'b0}};
    end else if (w_flush) begin
      r_wptr <= {PW{1'b0}};
      r_rptr <= {PW{1'b0}};
    end else begin
      if (w_push_eff) begin
        r_wptr <= r_wptr + {{(PW-1){1'b0}}, 1'b1};
      end
      if (w_pop_eff) begin
        r_rptr <= r_rptr + {{(PW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Entry storage: written on accepted push, deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_push_eff) begin
      r_mem[w_widx] <= issue_div_fifo_data_in;
    end
  end

  // Head presentation: zero when empty so the divide unit sees enable = 0.
  always_comb begin
    issue_div_fifo_data_out = '0;
    if (w_empty) begin
      issue_div_fifo_data_out = '0;
    end else begin
      issue_div_fifo_data_out = r_mem[w_ridx];
    end
  end

  assign issue_div_fifo_data_out_valid = !w_empty;
  assign issue_div_fifo_full           = w_full;
  // Modulo-2*DEPTH subtraction yields 0..DEPTH directly.
  assign issue_div_fifo_count          = r_wptr - r_rptr;

endmodule

// File: tb/tb_issue_div_fifo.sv
module tb_issue_div_fifo;
  import issue_div_fifo_pkg::*;

  logic                  clk;
  logic                  rst;
  issue_execute_pack_t   data_in;
  logic                  push;
  logic                  full;
  issue_execute_pack_t   data_out;
  logic                  valid;
  logic                  pop;
  logic [3:0]            count;
  commit_feedback_pack_t cfb;

  int total;
  int bad;

  issue_div_fifo #(.DEPTH(8)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .issue_div_fifo_data_in        (data_in),
    .issue_div_fifo_push           (push),
    .issue_div_fifo_full           (full),
    .issue_div_fifo_data_out       (data_out),
    .issue_div_fifo_data_out_valid (valid),
    .issue_div_fifo_pop            (pop),
    .issue_div_fifo_count          (count),
    .commit_feedback_pack          (cfb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic issue_execute_pack_t mk(input int rob);
    issue_execute_pack_t p;
    p.enable   = 1'b1;
    p.rob_id   = 6'(rob);
    p.div_op   = 2'(rob);
    p.rd_addr  = 5'(rob + 3);
    p.rs1_data = 32'h1000_0000 + 32'(rob * 7);
    p.rs2_data = 32'hA5A5_0000 ^ 32'(rob);
    return p;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, apply edge, return at next negedge.
  task automatic cyc(input logic p_push, input int rob, input logic p_pop,
                     input logic f_en, input logic f_fl);
    push       = p_push;
    data_in    = p_push ? mk(rob) : '0;
    pop        = p_pop;
    cfb.enable = f_en;
    cfb.flush  = f_fl;
    @(posedge clk);
    @(negedge clk);
    push       = 1'b0;
    pop        = 1'b0;
    data_in    = '0;
    cfb.enable = 1'b0;
    cfb.flush  = 1'b0;
  endtask

  task automatic check_head(input string tag, input int rob);
    check({tag, "_valid"}, 128'(valid), 128'(1'b1));
    check({tag, "_data"},  128'(data_out), 128'(mk(rob)));
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, 128'(valid), 128'(1'b0));
    check({tag, "_count"}, 128'(count), 128'(4'd0));
    check({tag, "_full"},  128'(full),  128'(1'b0));
    check({tag, "_data"},  128'(data_out), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    data_in    = '0;
    cfb.enable = 1'b0;
    cfb.flush  = 1'b0;
    repeat (2) @(negedge clk);
    check_empty("reset");
    rst = 1'b1;
    @(negedge clk);

    // Pop on empty is ignored.
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    check_empty("pop_empty");

    // Fill 1..8; first push visible one cycle later.
    cyc(1'b1, 1, 1'b0, 1'b0, 1'b0);
    check_head("push_latency", 1);
    check("count_after_1", 128'(count), 128'(4'd1));
    for (int i = 2; i <= 8; i++) cyc(1'b1, i, 1'b0, 1'b0, 1'b0);
    check("fill_full",  128'(full),  128'(1'b1));
    check("fill_count", 128'(count), 128'(4'd8));

    // Push while full is dropped.
    cyc(1'b1, 9, 1'b0, 1'b0, 1'b0);
    check("drop_count", 128'(count), 128'(4'd8));
    check_head("drop_head", 1);

    // Drain in order; full clears right after first pop.
    for (int i = 1; i <= 8; i++) begin
      check_head($sformatf("drain_%0d", i), i);
      cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
      if (i == 1) check("full_release", 128'(full), 128'(1'b0));
    end
    check_empty("drained");

    // Wrap-around: pointers now at 8; 6 in/out then 5 more crosses index 7->0.
    for (int i = 0; i < 6; i++) cyc(1'b1, 10 + i, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check_head($sformatf("wrapA_%0d", i), 10 + i);
      cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 20; i <= 24; i++) cyc(1'b1, i, 1'b0, 1'b0, 1'b0);
    check("wrap_count", 128'(count), 128'(4'd5));
    check("wrap_full",  128'(full),  128'(1'b0));
    for (int i = 20; i <= 24; i++) begin
      check_head($sformatf("wrapB_%0d", i), i);
      cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    end
    check_empty("wrap_drained");

    // Simultaneous push+pop at occupancy 3.
    for (int i = 30; i <= 32; i++) cyc(1'b1, i, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      check_head($sformatf("pp_%0d", k), 30 + k);
      cyc(1'b1, 33 + k, 1'b1, 1'b0, 1'b0);
      check($sformatf("pp_count_%0d", k), 128'(count), 128'(4'd3));
    end
    // Top up to 8 (40,41,42 present), then push+pop while full.
    for (int i = 43; i <= 47; i++) cyc(1'b1, i, 1'b0, 1'b0, 1'b0);
    check("pp_full", 128'(full), 128'(1'b1));
    cyc(1'b1, 50, 1'b1, 1'b0, 1'b0);
    check("pp_full_count", 128'(count), 128'(4'd7));
    check("pp_full_flag",  128'(full),  128'(1'b0));
    for (int i = 41; i <= 47; i++) begin
      check_head($sformatf("pp_drain_%0d", i), i);
      cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    end
    check_empty("pp_drained");

    // Flush beats push and pop in the same cycle.
    for (int i = 60; i <= 64; i++) cyc(1'b1, i, 1'b0, 1'b0, 1'b0);
    check("pre_flush_count", 128'(count), 128'(4'd5));
    cyc(1'b1, 65, 1'b1, 1'b1, 1'b1);
    check_empty("flush");
    cyc(1'b1, 70, 1'b0, 1'b0, 1'b0);
    check_head("post_flush", 70);
    check("post_flush_count", 128'(count), 128'(4'd1));

    // Flush without enable is not a flush.
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("noflush_count", 128'(count), 128'(4'd1));
    check_head("noflush_head", 70);

    // Asynchronous reset between edges at occupancy 4.
    for (int i = 71; i <= 73; i++) cyc(1'b1, i, 1'b0, 1'b0, 1'b0);
    check("pre_rst_count", 128'(count), 128'(4'd4));
    #2 rst = 1'b0;
    #1;
    check_empty("async_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cyc(1'b1, 7, 1'b0, 1'b0, 1'b0);
    check_head("post_rst", 7);
    check("post_rst_count", 128'(count), 128'(4'd1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
